// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
package reg_wb_pkg;
   localparam int REG_ADDR_W   = 5;
   localparam int NUM_REGS     = 32;
   localparam int DATA_W       = 64;
   localparam int ZERO_REG_DEF = 31;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     reg_data_t;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } wb_src_e;

   function automatic logic is_zero_reg(input reg_addr_t addr, input int zero_reg, input int zero_en);
      return (zero_en != 0) && (addr == reg_addr_t'(zero_reg));
   endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register outstanding-write counters with saturation, underflow error and read-port stall lookup.
module reg_scoreboard
   import reg_wb_pkg::*;
#(
   parameter int CNT_W       = 2,
   parameter int ZERO_REG    = ZERO_REG_DEF,
   parameter int ZERO_REG_EN = 1
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   input  logic      i_issue_valid,
   input  reg_addr_t i_issue_reg,
   output logic      o_issue_ready,
   input  logic      i_dec_valid,
   input  reg_addr_t i_dec_reg,
   input  reg_addr_t i_read_a,
   input  reg_addr_t i_read_b,
   output logic      o_stall_a,
   output logic      o_stall_b,
   output logic      o_sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]    r_cnt [NUM_REGS];
   logic                r_sb_err;
   logic                w_issue_zero;
   logic                w_dec_hit;
   logic                w_inc;
   logic                w_dec_underflow;
   logic                w_issue_overflow;
   logic [NUM_REGS-1:0] w_inc_vec;
   logic [NUM_REGS-1:0] w_dec_vec;

   assign w_issue_zero = is_zero_reg(i_issue_reg, ZERO_REG, ZERO_REG_EN);
   // A commit landing on the same edge frees a slot, so a saturated register may still accept an issue.
   assign w_dec_hit     = i_dec_valid && (i_dec_reg == i_issue_reg);
   assign o_issue_ready = w_issue_zero || (r_cnt[i_issue_reg] != CNT_MAX) || w_dec_hit;

   assign w_inc            = i_issue_valid && o_issue_ready && !w_issue_zero;
   assign w_dec_underflow  = i_dec_valid && (r_cnt[i_dec_reg] == '0);
   assign w_issue_overflow = i_issue_valid && !o_issue_ready;

   always_comb begin
      w_inc_vec              = '0;
      w_dec_vec              = '0;
      w_inc_vec[i_issue_reg] = w_inc;
      w_dec_vec[i_dec_reg]   = i_dec_valid;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            case ({w_inc_vec[i], w_dec_vec[i]})
               2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
               2'b01:   if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
               default: r_cnt[i] <= r_cnt[i];
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sb_err <= 1'b0;
      end else if (w_dec_underflow || w_issue_overflow) begin
         r_sb_err <= 1'b1;
      end
   end

   assign o_sb_err  = r_sb_err;
   assign o_stall_a = !is_zero_reg(i_read_a, ZERO_REG, ZERO_REG_EN) && (r_cnt[i_read_a] != '0);
   assign o_stall_b = !is_zero_reg(i_read_b, ZERO_REG, ZERO_REG_EN) && (r_cnt[i_read_b] != '0);

endmodule

// File: rtl/reg_wb_scheduler.sv
// Round-robin arbiter of ALU/load write-backs onto the single register-file write port,
// with a registered output stage and a scoreboard that stalls reads of in-flight registers.
module reg_wb_scheduler
   import reg_wb_pkg::*;
#(
   parameter int CNT_W       = 2,
   parameter int ZERO_REG    = ZERO_REG_DEF,
   parameter int ZERO_REG_EN = 1
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              ISSUE_VALID,
   input  logic [4:0]        ISSUE_REG,
   output logic              ISSUE_READY,
   input  logic              WB0_VALID,
   input  logic [4:0]        WB0_REG,
   input  logic [63:0]       WB0_DATA,
   output logic              WB0_READY,
   input  logic              WB1_VALID,
   input  logic [4:0]        WB1_REG,
   input  logic [63:0]       WB1_DATA,
   output logic              WB1_READY,
   input  logic [4:0]        READ_REG_A,
   input  logic [4:0]        READ_REG_B,
   output logic              STALL_A,
   output logic              STALL_B,
   output logic [4:0]        WRITE_REG,
   output logic [63:0]       WRITE_DATA,
   output logic              REG_WRITE_ENABLE,
   output logic              SB_ERR
);

   wb_src_e   r_last;
   reg_addr_t r_write_reg;
   reg_data_t r_write_data;
   logic      r_write_en;

   logic      w_gnt_alu;
   logic      w_gnt_mem;
   logic      w_gnt_any;
   logic      w_gnt_zero;
   reg_addr_t w_gnt_reg;
   reg_data_t w_gnt_data;

   assign w_gnt_alu  = WB0_VALID && (!WB1_VALID || (r_last == SRC_MEM));
   assign w_gnt_mem  = WB1_VALID && (!WB0_VALID || (r_last == SRC_ALU));
   assign w_gnt_any  = w_gnt_alu || w_gnt_mem;
   assign w_gnt_reg  = w_gnt_alu ? WB0_REG  : WB1_REG;
   assign w_gnt_data = w_gnt_alu ? WB0_DATA : WB1_DATA;
   assign w_gnt_zero = is_zero_reg(w_gnt_reg, ZERO_REG, ZERO_REG_EN);

   assign WB0_READY = w_gnt_alu;
   assign WB1_READY = w_gnt_mem;

   // Zero-register writes are consumed but never reach the file, so the output stage holds.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_last       <= SRC_MEM;
         r_write_reg  <= '0;
         r_write_data <= '0;
         r_write_en   <= 1'b0;
      end else begin
         r_write_en <= w_gnt_any && !w_gnt_zero;
         if (w_gnt_any && !w_gnt_zero) begin
            r_write_reg  <= w_gnt_reg;
            r_write_data <= w_gnt_data;
         end
         if (w_gnt_any) begin
            r_last <= w_gnt_alu ? SRC_ALU : SRC_MEM;
         end
      end
   end

   assign WRITE_REG        = r_write_reg;
   assign WRITE_DATA       = r_write_data;
   assign REG_WRITE_ENABLE = r_write_en;

   reg_scoreboard #(
      .CNT_W       (CNT_W),
      .ZERO_REG    (ZERO_REG),
      .ZERO_REG_EN (ZERO_REG_EN)
   ) u_scoreboard (
      .i_clk         (CLK),
      .i_rst_n       (RESET_N),
      .i_issue_valid (ISSUE_VALID),
      .i_issue_reg   (ISSUE_REG),
      .o_issue_ready (ISSUE_READY),
      .i_dec_valid   (r_write_en),
      .i_dec_reg     (r_write_reg),
      .i_read_a      (READ_REG_A),
      .i_read_b      (READ_REG_B),
      .o_stall_a     (STALL_A),
      .o_stall_b     (STALL_B),
      .o_sb_err      (SB_ERR)
   );

endmodule
